// File: rtl/integer_multiplier_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the state encoding exposed on CS and the iteration counter width.
package integer_multiplier_seq_pkg;

    localparam int CS_W  = 3;
    localparam int CNT_W = 4;

    typedef enum logic [CS_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHK   = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/integer_multiplier_seq_if.sv
// Go/Done/CS handshake bundle between the calculator and the multiplier.
interface integer_multiplier_seq_if #(
    parameter int W = 4
);
    import integer_multiplier_seq_pkg::*;

    logic              Go;
    logic [W-1:0]      Multiplicand;
    logic [W-1:0]      Multiplier;
    logic [2*W-1:0]    Product;
    logic              Ovf;
    logic              Done;
    logic [CS_W-1:0]   CS;

    modport master (
        output Go, Multiplicand, Multiplier,
        input  Product, Ovf, Done, CS
    );

    modport slave (
        input  Go, Multiplicand, Multiplier,
        output Product, Ovf, Done, CS
    );

endinterface

// File: rtl/integer_multiplier_seq_dp.sv
// Multiplier datapath: shifted multiplicand, multiplier shift register,
// accumulator, iteration counter and the held result registers.
module integer_multiplier_seq_dp
    import integer_multiplier_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_ops,
    input  logic             clr_p,
    input  logic             add_en,
    input  logic             shift_en,
    input  logic             res_ld,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             q_lsb,
    output logic             cnt_zero,
    output logic [2*W-1:0]   product,
    output logic             ovf
);

    logic [2*W-1:0]   ms;
    logic [W-1:0]     q;
    logic [2*W-1:0]   p;
    logic [CNT_W-1:0] cnt;

    // Control strobes are mutually exclusive per state, so no priority is needed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ms      <= '0;
            q       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            if (ld_ops) begin
                ms <= {{W{1'b0}}, a};
                q  <= b;
            end
            if (clr_p) begin
                p   <= '0;
                cnt <= CNT_W'(W);
            end
            if (add_en) begin
                p <= p + ms;
            end
            if (shift_en) begin
                ms  <= ms << 1;
                q   <= q >> 1;
                cnt <= cnt - 4'd1;
            end
            if (res_ld) begin
                product <= p;
                ovf     <= |p[2*W-1:W];
            end
        end
    end

    assign q_lsb    = q[0];
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/integer_multiplier_seq.sv
// Sequential shift-add unsigned multiplier: control FSM around the datapath.
//   state | meaning
//   IDLE  | wait for Go, capture operands
//   LOAD  | clear accumulator, load bit counter
//   CHK   | test remaining bits and multiplier LSB
//   ADD   | accumulate shifted multiplicand
//   SHIFT | advance to next multiplier bit
//   DONE  | result valid, hold until Go drops
module integer_multiplier_seq
    import integer_multiplier_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    integer_multiplier_seq_if.slave   bus
);

    state_t state, state_nxt;
    logic   ld_ops, clr_p, add_en, shift_en, res_ld;
    logic   q_lsb, cnt_zero;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_ops    = 1'b0;
        clr_p     = 1'b0;
        add_en    = 1'b0;
        shift_en  = 1'b0;
        res_ld    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Go) begin
                    ld_ops    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                clr_p     = 1'b1;
                state_nxt = S_CHK;
            end
            S_CHK: begin
                if (cnt_zero) begin
                    res_ld    = 1'b1;
                    state_nxt = S_DONE;
                end else if (q_lsb) begin
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_ADD: begin
                add_en    = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en  = 1'b1;
                state_nxt = S_CHK;
            end
            S_DONE: begin
                // Level-held Go keeps us here so it cannot retrigger a new run.
                if (!bus.Go) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    integer_multiplier_seq_dp #(.W(W)) u_dp (
        .CLK      (CLK),
        .RST      (RST),
        .ld_ops   (ld_ops),
        .clr_p    (clr_p),
        .add_en   (add_en),
        .shift_en (shift_en),
        .res_ld   (res_ld),
        .a        (bus.Multiplicand),
        .b        (bus.Multiplier),
        .q_lsb    (q_lsb),
        .cnt_zero (cnt_zero),
        .product  (bus.Product),
        .ovf      (bus.Ovf)
    );

    assign bus.Done = (state == S_DONE);
    assign bus.CS   = state;

endmodule

// File: tb/tb_integer_multiplier_seq.sv
// Self-checking bench for integer_multiplier_seq (W=4): vector table plus
// hand-written handshake, retrigger and reset sequences.
module tb_integer_multiplier_seq;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        logic           o;
        int             lat;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        logic           o;
        int             lat;
    } exp_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   go_cyc;
    int   n_vec;
    int   n_miss;
    exp_t sb[$];
    vec_t vecs[10];
    int   cs_seq[13];

    integer_multiplier_seq_if #(.W(W)) bus ();

    integer_multiplier_seq #(.W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic go_start(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] ep, input logic eo, input int el,
                            input bit push);
        exp_t e;
        @(negedge CLK);
        bus.Go           = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        @(posedge CLK);
        #1;
        go_cyc = cyc;
        e.p   = ep;
        e.o   = eo;
        e.lat = el;
        if (push) sb.push_back(e);
    endtask

    task automatic collect();
        int   guard;
        exp_t e;
        guard = 0;
        while (!bus.Done && guard < 40) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("done_seen", 32'(bus.Done), 1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("latency", cyc - go_cyc, e.lat);
            chk("product", 32'(bus.Product), 32'(e.p));
            chk("ovf", 32'(bus.Ovf), 32'(e.o));
            chk("cs_done", 32'(bus.CS), 5);
        end
    endtask

    task automatic finish_op();
        @(negedge CLK);
        bus.Go = 1'b0;
        @(posedge CLK);
        #1;
        chk("cs_idle", 32'(bus.CS), 0);
        chk("done_low", 32'(bus.Done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_vec  = 0;
        n_miss = 0;
        vecs[0] = '{4'd3,  4'd5,  8'd15,  1'b0, 12};
        vecs[1] = '{4'd15, 4'd15, 8'd225, 1'b1, 14};
        vecs[2] = '{4'd9,  4'd0,  8'd0,   1'b0, 10};
        vecs[3] = '{4'd0,  4'd7,  8'd0,   1'b0, 13};
        vecs[4] = '{4'd1,  4'd1,  8'd1,   1'b0, 11};
        vecs[5] = '{4'd8,  4'd8,  8'd64,  1'b1, 11};
        vecs[6] = '{4'd15, 4'd1,  8'd15,  1'b0, 11};
        vecs[7] = '{4'd4,  4'd4,  8'd16,  1'b1, 11};
        vecs[8] = '{4'd7,  4'd9,  8'd63,  1'b1, 12};
        vecs[9] = '{4'd12, 4'd10, 8'd120, 1'b1, 12};
        cs_seq  = '{1, 2, 3, 4, 2, 4, 2, 3, 4, 2, 4, 2, 5};

        RST              = 1'b0;
        bus.Go           = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_product", 32'(bus.Product), 0);
        chk("rst_ovf", 32'(bus.Ovf), 0);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_cs", 32'(bus.CS), 0);
        @(negedge CLK);
        RST = 1'b1;

        // CS trace for 3*5
        go_start(4'd3, 4'd5, 8'd15, 1'b0, 12, 1'b1);
        chk("cs_trace_0", 32'(bus.CS), 32'(cs_seq[0]));
        @(negedge CLK);
        bus.Go = 1'b0;
        for (int i = 1; i < 13; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("cs_trace_%0d", i), 32'(bus.CS), 32'(cs_seq[i]));
        end
        collect();
        finish_op();

        // Table vectors; operands are scrambled after the Go edge
        for (int i = 0; i < 10; i++) begin
            go_start(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, vecs[i].lat, 1'b1);
            @(negedge CLK);
            bus.Go           = 1'b0;
            bus.Multiplicand = W'($urandom);
            bus.Multiplier   = W'($urandom);
            collect();
            finish_op();
        end

        // Go held high through DONE
        go_start(4'd6, 4'd2, 8'd12, 1'b0, 11, 1'b1);
        collect();
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk("hold_done", 32'(bus.Done), 1);
            chk("hold_cs", 32'(bus.CS), 5);
        end
        finish_op();
        chk("hold_product", 32'(bus.Product), 12);

        // Go pulsed with new operands while busy
        go_start(4'd5, 4'd3, 8'd15, 1'b0, 12, 1'b1);
        @(negedge CLK);
        bus.Go = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        bus.Go           = 1'b1;
        bus.Multiplicand = 4'd15;
        bus.Multiplier   = 4'd15;
        @(negedge CLK);
        bus.Go = 1'b0;
        collect();
        finish_op();

        // Asynchronous reset during ADD
        go_start(4'd7, 4'd7, 8'd0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        bus.Go = 1'b0;
        guard = 0;
        while (bus.CS != 3'd3 && guard < 20) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("reached_add", 32'(bus.CS), 3);
        #2;
        RST = 1'b0;
        #1;
        chk("abort_cs", 32'(bus.CS), 0);
        chk("abort_product", 32'(bus.Product), 0);
        chk("abort_done", 32'(bus.Done), 0);
        @(negedge CLK);
        RST = 1'b1;
        go_start(4'd2, 4'd3, 8'd6, 1'b0, 12, 1'b1);
        @(negedge CLK);
        bus.Go = 1'b0;
        collect();
        finish_op();

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/integer_multiplier_seq.md
Name: integer_multiplier_seq

Overview:
- Sequential shift-add unsigned integer multiplier for the calculator.
- It is the inverse-operation companion of the restoring integer divider and shares its Go/Done/CS handshake style.
- Accepts two W-bit operands on Go and produces a 2W-bit product over multiple cycles.
- Exposes FSM state on CS for the calculator display/debug path.

Parameters:
- W, 4, operand width in bits; product is 2W bits; W range 2..8; internal counter is 4 bits.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- Go  input  1  start request, level-sampled in IDLE
- Multiplicand  input  W  operand A, unsigned
- Multiplier  input  W  operand B, unsigned
- Product  output  2W  registered result A*B
- Ovf  output  1  registered; 1 when Product[2W-1:W] != 0, i.e. the result does not fit W-bit display
- Done  output  1  high while in DONE state
- CS  output  3  current FSM state code

Behaviour:
- Reset is asynchronous, active-low: RST=0 forces state IDLE and clears all registers immediately. Product=0, Ovf=0, Done=0, CS=0.
- Reset asserted mid-operation aborts the operation. No partial result is retained.
- State codes: IDLE=0, LOAD=1, CHK=2, ADD=3, SHIFT=4, DONE=5. Codes 6 and 7 are unreachable; if entered, go to IDLE next edge.
- IDLE: when Go=1 at an edge, capture Multiplicand into MS (2W-bit, zero-extended) and Multiplier into Q (W-bit), then go to LOAD. Otherwise stay in IDLE.
- Operands are sampled only at the Go-sampling edge. Later operand changes are ignored.
- LOAD: clear P (the 2W-bit accumulator), set cnt=W, then go to CHK.
- CHK:
  - cnt==0: go to DONE.
  - cnt!=0 and Q[0]=1: go to ADD.
  - cnt!=0 and Q[0]=0: go to SHIFT.
- ADD: P <= P + MS, modulo 2^2W. No carry is lost, because the true product always fits in 2W bits. Then go to SHIFT.
- SHIFT: MS <= MS << 1 (zero fill); Q <= Q >> 1 (zero fill); cnt <= cnt - 1. Then go to CHK.
- DONE: Product and Ovf are updated from P on the edge entering DONE, and Done=1.
  - Stay in DONE while Go=1.
  - Go to IDLE when Go=0; Done drops on that edge.
  - Holding Go high therefore never retriggers.
- Product and Ovf hold their value until the next entry to DONE. They are not cleared by LOAD.
- Go while in LOAD/CHK/ADD/SHIFT is ignored.
- Latency: Done=1 exactly N rising edges after the Go-sampling edge, where N = 2 + 2W + popcount(B). For W=4, N ranges from 10 to 14.
- Zero operands take the normal path; there is no shortcut. A=0 still runs popcount(B) ADDs of zero.
- CS is a direct registered state encoding, so it changes only on clock edges or on reset.

Decomposition:
- Shared header file mult_defs.vh holds:
  - state code localparams: S_IDLE, S_LOAD, S_CHK, S_ADD, S_SHIFT, S_DONE;
  - the CS width (3).
- One sub-module, mult_DP, is natural. It holds the MS, Q, P and cnt registers and the adder, and outputs q_lsb and cnt_zero.
- Control inputs to mult_DP: ld_ops, clr_p, add_en, shift_en, res_ld.
- The FSM and output logic stay in integer_multiplier_seq.

Test Plan:
- W=4, A=3, B=5, Go pulse → Done rises 12 edges after the Go-sampling edge; Product=15 (0x0F), Ovf=0; CS sequence 0,1,2,3,4,2,4,2,3,4,2,4,2,5.
- A=15, B=15 → Done after 14 edges; Product=225 (0xE1), Ovf=1.
- A=9, B=0 → Done after 10 edges; Product=0, Ovf=0. Then a second run with A=0, B=7 → Product=0, Done after 13 edges.
- A=6, B=2, Go held high through DONE → remains in DONE with Done=1 for at least 5 extra cycles. Drop Go → CS=0 and Done=0 on the next edge. Product stays 12.
- A=5, B=3 started; change operands to A=15, B=15 and pulse Go while busy → result is still Product=15, with no restart.
- Start A=7, B=7, assert RST=0 asynchronously mid-ADD → immediately CS=0, Product=0, Done=0. Release RST, run A=2, B=3 → Product=6.
